// File: rtl/p4_router_pkg.sv
// p4_router_pkg: shared definitions for the P4 router datapath.
//   - port-width indices and the widest egress beat size
//   - get_port_bytes(): bytes per beat of a port-width index (8 << index)
//   - egress downsizer FSM state type
package p4_router_pkg;

    localparam int unsigned MAX_PORT_BYTES = 64;

    localparam int unsigned INDEX_8B  = 0;
    localparam int unsigned INDEX_16B = 1;
    localparam int unsigned INDEX_32B = 2;
    localparam int unsigned INDEX_64B = 3;

    typedef enum logic {
        EMPTY,
        EMIT
    } egr_state_e;

    function automatic int unsigned get_port_bytes(input int unsigned index);
        return 32'd8 << index;
    endfunction

endpackage

// File: rtl/p4_router_keep_slice_finder.sv
// p4_router_keep_slice_finder: slice mux and final-slice detection for the
// egress downsizer.
// Ports:
//   load_keep, load_last  : beat being loaded (used to compute last_idx)
//   last_idx              : index of the final slice of the loading beat
//   hold_data, hold_keep  : currently held beat
//   slice_idx             : slice to present
//   slice_data, slice_keep: selected slice of the held beat
module p4_router_keep_slice_finder #(
    parameter int unsigned IN_BYTES  = 64,
    parameter int unsigned OUT_BYTES = 64,
    localparam int unsigned R        = IN_BYTES / OUT_BYTES,
    localparam int unsigned IDX_W    = (R > 1) ? $clog2(R) : 1
) (
    input  logic [IN_BYTES-1:0]    load_keep,
    input  logic                   load_last,
    output logic [IDX_W-1:0]       last_idx,
    input  logic [IN_BYTES*8-1:0]  hold_data,
    input  logic [IN_BYTES-1:0]    hold_keep,
    input  logic [IDX_W-1:0]       slice_idx,
    output logic [OUT_BYTES*8-1:0] slice_data,
    output logic [OUT_BYTES-1:0]   slice_keep
);

    // Non-last beats emit every slice. Last beats stop at the highest slice
    // holding any keep bit; an all-zero keep still yields slice 0.
    always_comb begin
        last_idx = IDX_W'(R - 1);
        if (load_last) begin
            last_idx = '0;
            for (int unsigned k = 0; k < R; k++) begin
                if (|load_keep[k*OUT_BYTES +: OUT_BYTES]) begin
                    last_idx = IDX_W'(k);
                end
            end
        end
    end

    always_comb begin
        slice_data = '0;
        slice_keep = '0;
        for (int unsigned k = 0; k < R; k++) begin
            if (slice_idx == IDX_W'(k)) begin
                slice_data = hold_data[k*OUT_BYTES*8 +: OUT_BYTES*8];
                slice_keep = hold_keep[k*OUT_BYTES +: OUT_BYTES];
            end
        end
    end

endmodule

// File: rtl/p4_router_egr_downsizer.sv
// p4_router_egr_downsizer: egress width converter. Holds one 64 B core beat
// and serialises it as OUT_BYTES = 8 << PORT_WIDTH_INDEX slices onto the
// port stream. Full rate: the next beat loads as the final slice is taken.
// Ports:
//   clk, aresetn          : core clock, asynchronous active-low reset
//   s_t*                  : wide AXI-Stream input (data/keep/user/last/valid/ready)
//   m_t*                  : narrow AXI-Stream output
//   stat_pkt_cnt (32 b), stat_byte_cnt (48 b): only with the
//   P4_ROUTER_EGR_DOWNSIZER_STATS_EN macro defined
module p4_router_egr_downsizer
    import p4_router_pkg::*;
#(
    parameter int unsigned IN_BYTES         = MAX_PORT_BYTES,
    parameter int unsigned PORT_WIDTH_INDEX = INDEX_64B,
    parameter int unsigned TUSER_W          = 16,
    localparam int unsigned OUT_BYTES       = get_port_bytes(PORT_WIDTH_INDEX),
    localparam int unsigned R               = IN_BYTES / OUT_BYTES,
    localparam int unsigned IDX_W           = (R > 1) ? $clog2(R) : 1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [IN_BYTES*8-1:0]  s_tdata,
    input  logic [IN_BYTES-1:0]    s_tkeep,
    input  logic [TUSER_W-1:0]     s_tuser,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [OUT_BYTES*8-1:0] m_tdata,
    output logic [OUT_BYTES-1:0]   m_tkeep,
    output logic [TUSER_W-1:0]     m_tuser,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]            stat_pkt_cnt,
    output logic [47:0]            stat_byte_cnt
`endif
);

    egr_state_e            state, state_nx;
    logic [IDX_W-1:0]      slice_idx, slice_idx_nx;
    logic [IDX_W-1:0]      last_idx, load_last_idx;
    logic [IN_BYTES*8-1:0] hold_data;
    logic [IN_BYTES-1:0]   hold_keep;
    logic [TUSER_W-1:0]    hold_user;
    logic                  hold_last;
    logic                  load;
    logic                  final_slice;

    p4_router_keep_slice_finder #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES)
    ) u_finder (
        .load_keep  (s_tkeep),
        .load_last  (s_tlast),
        .last_idx   (load_last_idx),
        .hold_data  (hold_data),
        .hold_keep  (hold_keep),
        .slice_idx  (slice_idx),
        .slice_data (m_tdata),
        .slice_keep (m_tkeep)
    );

    assign final_slice = (slice_idx == last_idx);
    assign m_tuser     = hold_user;
    assign m_tlast     = (state == EMIT) && hold_last && final_slice;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= EMPTY;
            slice_idx <= '0;
        end else begin
            state     <= state_nx;
            slice_idx <= slice_idx_nx;
        end
    end

    // Hold register is cleared on reset so the idle outputs read as zero;
    // a partially emitted beat is simply dropped.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hold_data <= '0;
            hold_keep <= '0;
            hold_user <= '0;
            hold_last <= 1'b0;
            last_idx  <= '0;
        end else if (load) begin
            hold_data <= s_tdata;
            hold_keep <= s_tkeep;
            hold_user <= s_tuser;
            hold_last <= s_tlast;
            last_idx  <= load_last_idx;
        end
    end

    always_comb begin
        state_nx     = state;
        slice_idx_nx = slice_idx;
        load         = 1'b0;
        s_tready     = 1'b0;
        m_tvalid     = 1'b0;
        case (state)
            EMPTY: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    load         = 1'b1;
                    slice_idx_nx = '0;
                    state_nx     = EMIT;
                end
            end
            EMIT: begin
                m_tvalid = 1'b1;
                s_tready = m_tready && final_slice;
                if (m_tready) begin
                    if (!final_slice) begin
                        slice_idx_nx = slice_idx + 1'b1;
                    end else if (s_tvalid) begin
                        load         = 1'b1;
                        slice_idx_nx = '0;
                    end else begin
                        state_nx = EMPTY;
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else if (m_tvalid && m_tready) begin
            if (m_tlast) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
            stat_byte_cnt <= stat_byte_cnt + 48'($countones(m_tkeep));
        end
    end
`endif

endmodule

// File: doc/p4_router_egr_downsizer.md
Name: p4_router_egr_downsizer

Overview:
- Egress-side width converter for the P4 router. It takes the router core's widest egress AXI-Stream beat (64 B) and serialises it onto one narrower physical-port stream (8/16/32/64 B).
- One instance sits per egress port between the core and the egress port array selected by PORT_WIDTH_INDEX.
- It is the egress counterpart of the ingress width aggregation.

Parameters:
- IN_BYTES, 64, input data width in bytes; fixed to the widest array.
- PORT_WIDTH_INDEX, INDEX_64B, port-width index of the output; OUT_BYTES = 8 << PORT_WIDTH_INDEX.
- TUSER_W, 16, per-beat sideband width (egress port/metadata), copied unchanged onto every output slice.

Ports:
- clk  in  1  core clock
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  IN_BYTES*8  input data; byte 0 in bits [7:0]
- s_tkeep  in  IN_BYTES  input byte enables; contiguous from byte 0
- s_tuser  in  TUSER_W  input sideband
- s_tlast  in  1  end of packet
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  OUT_BYTES*8  output data
- m_tkeep  out  OUT_BYTES  output byte enables
- m_tuser  out  TUSER_W  output sideband
- m_tlast  out  1  end of packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready

Behaviour:
- Ratio and slicing: R = IN_BYTES/OUT_BYTES (1, 2, 4 or 8). Slice k is bytes [k*OUT_BYTES +: OUT_BYTES] of the held beat.
- Reset values: m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, m_tuser=0, s_tready=1. State is EMPTY and slice_idx=0.
- Reset is asynchronous and may assert mid-packet. The held beat is discarded and the partial packet is not completed; downstream relies on the port MAC to drop the runt.
- Hold register: one input beat is held. This is the only buffering.
- s_tready = (state==EMPTY) OR (m_tready AND the current slice is the final slice).
- Throughput: full rate. A new beat is loaded in the same cycle the final slice is accepted, so the next beat's first slice is presented in the following cycle with no bubble.
- Latency: first slice appears 1 cycle after input acceptance.
- State EMPTY: m_tvalid=0. On s_tvalid, load the beat, set slice_idx=0, go to EMIT.
- State EMIT: present slice slice_idx with m_tvalid=1.
  - On m_tready, if the slice is not final, increment slice_idx.
  - If the slice is final, either load a waiting s_tvalid beat (stay in EMIT, slice_idx=0) or go to EMPTY.
- Final slice:
  - Non-tlast beat: slice R-1. All R slices are emitted and tkeep is passed unchanged.
  - tlast beat: the last slice k with any tkeep bit set. It carries m_tlast=1. Trailing all-zero slices are never emitted.
- Zero-keep tlast beat (s_tkeep all 0 with s_tlast=1): emit exactly one slice (slice 0) with m_tkeep=0, m_tlast=1.
- m_tlast is 0 on every slice other than the final slice of a tlast beat.
- Output stability: m_tdata, m_tkeep, m_tuser and m_tlast are stable while m_tvalid=1 and m_tready=0.
- R=1: behaves as a one-register pipeline stage with identical handshake.
- slice_idx width: max($clog2(R),1). It never wraps beyond R-1.

Optional Feature:
- Macro: P4_ROUTER_EGR_DOWNSIZER_STATS_EN.
- Enabled, adds two outputs:
  - stat_pkt_cnt (32 b): increments on each accepted m_tlast slice.
  - stat_byte_cnt (48 b): adds popcount(m_tkeep) on each accepted slice.
  - Both counters reset to 0, wrap modulo 2^N and are free-running.
- Disabled: the ports and logic are absent and the datapath is identical.

Decomposition:
- p4_router_pkg gains:
  - function get_port_bytes(index) returning 8 << index.
  - localparam MAX_PORT_BYTES = 64.
- Slice selection and final-slice detection (highest non-zero keep slice, computed at load time and stored as last_idx) form one sub-module, p4_router_keep_slice_finder.
- The FSM and hold register stay in the top.

Test Plan:
- PORT_WIDTH_INDEX=INDEX_8B, one 64 B beat, tkeep all 1, tlast=1, m_tready=1:
  - 8 slices on consecutive cycles, bytes 0..63 in order.
  - m_tlast only on slice 7.
  - s_tready low for cycles 1-7 of the beat.
- INDEX_16B, 100 B packet (64 B beat, then 36 B tlast beat with tkeep=0x0000000FFFFFFFFF):
  - 4 + 3 slices with no bubble between beats.
  - Last slice m_tkeep=0x000F, m_tlast=1.
- INDEX_32B, zero-keep tlast beat:
  - Exactly one slice with m_tkeep=0, m_tlast=1; then EMPTY.
- Random m_tready backpressure (50 %) on 1000 random-length packets, INDEX_8B..64B:
  - Output byte stream and tuser match the scoreboard.
  - Outputs are stable while stalled.
- aresetn pulsed low after slice 2 of 4:
  - All outputs reset immediately; s_tready=1.
  - The next packet emits correctly from slice 0.
- With P4_ROUTER_EGR_DOWNSIZER_STATS_EN, 3 packets of 64, 65 and 1 B:
  - stat_pkt_cnt=3, stat_byte_cnt=130.
